// File: rtl/bp_be_retire_collector_if.sv
// ============================================================================
// Module   : bp_be_retire_collector_if
// Purpose  : Issue / retire / retire-packet bundle between dispatch, the
//            retire collector and the CSR unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_be_retire_collector_if
  #(parameter int lanes_p       = 2
  , parameter int vaddr_width_p = 39
  , parameter int instr_width_p = 32
  , parameter int dword_width_p = 64
  , parameter int exc_width_p   = 16
  , parameter int cnt_width_p   = 64
  );

  // Issue side (stage 0 capture)
  logic                               flush_i;
  logic [lanes_p-1:0]                 issue_v_i;
  logic [lanes_p*vaddr_width_p-1:0]   issue_pc_i;
  logic [lanes_p*instr_width_p-1:0]   issue_instr_i;
  logic [lanes_p*dword_width_p-1:0]   issue_rs1_i;
  logic [lanes_p*dword_width_p-1:0]   issue_imm_i;

  // Retire requests, aligned to stage 1
  logic [lanes_p-1:0]                 retire_v_i;
  logic [lanes_p*exc_width_p-1:0]     retire_exception_i;

  // Retire packets
  logic [lanes_p-1:0]                 ret_v_o;
  logic [lanes_p-1:0]                 ret_instret_o;
  logic [lanes_p*vaddr_width_p-1:0]   ret_pc_o;
  logic [lanes_p*vaddr_width_p-1:0]   ret_npc_o;
  logic [lanes_p*vaddr_width_p-1:0]   ret_vaddr_o;
  logic [lanes_p*instr_width_p-1:0]   ret_instr_o;
  logic [lanes_p*exc_width_p-1:0]     ret_exception_o;
  logic [cnt_width_p-1:0]             instret_cnt_o;
  logic                               order_err_o;

  modport master
    (output flush_i, issue_v_i, issue_pc_i, issue_instr_i, issue_rs1_i, issue_imm_i
    ,output retire_v_i, retire_exception_i
    ,input  ret_v_o, ret_instret_o, ret_pc_o, ret_npc_o, ret_vaddr_o, ret_instr_o
    ,input  ret_exception_o, instret_cnt_o, order_err_o
    );

  modport slave
    (input  flush_i, issue_v_i, issue_pc_i, issue_instr_i, issue_rs1_i, issue_imm_i
    ,input  retire_v_i, retire_exception_i
    ,output ret_v_o, ret_instret_o, ret_pc_o, ret_npc_o, ret_vaddr_o, ret_instr_o
    ,output ret_exception_o, instret_cnt_o, order_err_o
    );

endinterface

`default_nettype wire

// File: rtl/bp_be_retire_collector.sv
// ============================================================================
// Module   : bp_be_retire_collector
// Purpose  : N-lane retire packet builder. Delays each issued group two
//            cycles to line up with commit, kills lanes younger than an
//            excepting lane, chains npc across lanes and groups and keeps a
//            running instret count.
// Options  : BP_BE_RETIRE_RVC_EN - fallthrough is +2 for compressed instrs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_retire_collector
  #(parameter int lanes_p       = 2
  , parameter int vaddr_width_p = 39
  , parameter int instr_width_p = 32
  , parameter int dword_width_p = 64
  , parameter int exc_width_p   = 16
  , parameter int cnt_width_p   = 64
  )
  (input  logic                         clk_i
  ,input  logic                         reset_i
  ,bp_be_retire_collector_if.slave      bus
  );

  localparam int c_pop_w = $clog2(lanes_p + 1);

  typedef logic [vaddr_width_p-1:0] vaddr_t;
  typedef logic [instr_width_p-1:0] instr_t;
  typedef logic [exc_width_p-1:0]   exc_t;

  // Pipeline state
  logic   [lanes_p-1:0] r_s0_v, r_s1_v;
  vaddr_t [lanes_p-1:0] r_s0_pc, r_s1_pc;
  vaddr_t [lanes_p-1:0] r_s0_vaddr, r_s1_vaddr;
  instr_t [lanes_p-1:0] r_s0_instr, r_s1_instr;
  logic [cnt_width_p-1:0] r_instret_cnt;
  logic                   r_order_err;

  // Combinational
  vaddr_t [lanes_p-1:0] w_issue_vaddr;
  exc_t   [lanes_p-1:0] w_exc;
  logic   [lanes_p-1:0] w_eff_v;
  logic   [lanes_p-1:0] w_instret;
  logic                 w_kill;
  logic   [lanes_p-1:0] w_s0_vis;
  vaddr_t               w_s0_npc;
  vaddr_t [lanes_p-1:0] w_fall;
  vaddr_t [lanes_p-1:0] w_npc;
  vaddr_t [lanes_p-1:0] w_ret_pc, w_ret_npc, w_ret_vaddr;
  instr_t [lanes_p-1:0] w_ret_instr;
  exc_t   [lanes_p-1:0] w_ret_exc;
  logic   [c_pop_w-1:0] w_pop;
  logic                 w_err;
  logic                 w_hole;

  assign w_exc = bus.retire_exception_i;

  // Effective address per lane; only the low vaddr bits are architectural
  for (genvar k = 0; k < lanes_p; k++) begin : g_vaddr
    logic [dword_width_p-vaddr_width_p-1:0] w_sum_unused;
    assign {w_sum_unused, w_issue_vaddr[k]} =
        bus.issue_rs1_i[k*dword_width_p +: dword_width_p]
      + bus.issue_imm_i[k*dword_width_p +: dword_width_p];
  end

  // Stage 0: capture the issued group every cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s0_v     <= '0;
      r_s0_pc    <= '0;
      r_s0_instr <= '0;
      r_s0_vaddr <= '0;
    end else begin
      r_s0_v     <= bus.issue_v_i;
      r_s0_pc    <= bus.issue_pc_i;
      r_s0_instr <= bus.issue_instr_i;
      r_s0_vaddr <= w_issue_vaddr;
    end
  end

  // Stage 1: copy stage 0, dropping its valids when the group is flushed
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_v     <= '0;
      r_s1_pc    <= '0;
      r_s1_instr <= '0;
      r_s1_vaddr <= '0;
    end else begin
      r_s1_v     <= bus.flush_i ? '0 : r_s0_v;
      r_s1_pc    <= r_s0_pc;
      r_s1_instr <= r_s0_instr;
      r_s1_vaddr <= r_s0_vaddr;
    end
  end

  // In-order qualification: an excepting lane kills every younger lane
  always_comb begin
    w_kill    = 1'b0;
    w_eff_v   = '0;
    w_instret = '0;
    for (int k = 0; k < lanes_p; k++) begin
      w_eff_v[k]   = bus.retire_v_i[k] & r_s1_v[k] & ~w_kill;
      w_instret[k] = w_eff_v[k] & ~(|w_exc[k]);
      w_kill       = w_kill | (w_eff_v[k] & (|w_exc[k]));
    end
  end

  // Sequential fallthrough pc per lane
  always_comb begin
    w_fall = '0;
    for (int k = 0; k < lanes_p; k++) begin
`ifdef BP_BE_RETIRE_RVC_EN
      w_fall[k] = r_s1_pc[k] + ((r_s1_instr[k][1:0] != 2'b11) ? vaddr_t'(2) : vaddr_t'(4));
`else
      w_fall[k] = r_s1_pc[k] + vaddr_t'(4);
`endif
    end
  end

  // npc: next younger valid stage-1 lane, else oldest live stage-0 lane,
  // else fallthrough. A group being flushed never supplies an npc.
  always_comb begin
    w_s0_vis = r_s0_v & {lanes_p{~bus.flush_i}};
    w_s0_npc = '0;
    for (int j = lanes_p - 1; j >= 0; j--) begin
      if (w_s0_vis[j]) w_s0_npc = r_s0_pc[j];
    end
    w_npc = '0;
    for (int k = 0; k < lanes_p; k++) begin
      w_npc[k] = (|w_s0_vis) ? w_s0_npc : w_fall[k];
      for (int j = lanes_p - 1; j >= 0; j--) begin
        if ((j > k) && r_s1_v[j]) w_npc[k] = r_s1_pc[j];
      end
    end
  end

  // Retire packet fields are zero on lanes that do not retire
  always_comb begin
    w_ret_pc    = '0;
    w_ret_npc   = '0;
    w_ret_vaddr = '0;
    w_ret_instr = '0;
    w_ret_exc   = '0;
    for (int k = 0; k < lanes_p; k++) begin
      if (w_eff_v[k]) begin
        w_ret_pc[k]    = r_s1_pc[k];
        w_ret_npc[k]   = w_npc[k];
        w_ret_vaddr[k] = r_s1_vaddr[k];
        w_ret_instr[k] = r_s1_instr[k];
        w_ret_exc[k]   = w_exc[k];
      end
    end
  end

  // Number of instructions retiring cleanly this cycle
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < lanes_p; k++) begin
      w_pop = w_pop + c_pop_w'(w_instret[k]);
    end
  end

  // Running instret count, wraps naturally
  always_ff @(posedge clk_i) begin
    if (reset_i) r_instret_cnt <= '0;
    else         r_instret_cnt <= r_instret_cnt + cnt_width_p'(w_pop);
  end

  // Protocol violation: retire on an empty lane, or past an older valid
  // lane that is not retiring
  always_comb begin
    w_err  = 1'b0;
    w_hole = 1'b0;
    for (int k = 0; k < lanes_p; k++) begin
      if (bus.retire_v_i[k] & (~r_s1_v[k] | w_hole)) w_err = 1'b1;
      w_hole = w_hole | (r_s1_v[k] & ~bus.retire_v_i[k]);
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i)    r_order_err <= 1'b0;
    else if (w_err) r_order_err <= 1'b1;
  end

  assign bus.ret_v_o         = w_eff_v;
  assign bus.ret_instret_o   = w_instret;
  assign bus.ret_pc_o        = w_ret_pc;
  assign bus.ret_npc_o       = w_ret_npc;
  assign bus.ret_vaddr_o     = w_ret_vaddr;
  assign bus.ret_instr_o     = w_ret_instr;
  assign bus.ret_exception_o = w_ret_exc;
  assign bus.instret_cnt_o   = r_instret_cnt;
  assign bus.order_err_o     = r_order_err;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_retire_collector.sv
// ============================================================================
// Module   : tb_bp_be_retire_collector
// Purpose  : Scoreboard bench for bp_be_retire_collector (2 lanes, defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_retire_collector;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bp_be_retire_collector_if bus ();

  bp_be_retire_collector dut
    (.clk_i   (clk)
    ,.reset_i (reset)
    ,.bus     (bus)
    );

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [15:0] e0, e1;
    logic [1:0]  ev, ei;
    logic [38:0] pc0, pc1, npc0, npc1, va0, va1;
    logic [31:0] in0, in1;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int due, input logic [1:0] rv, input logic [15:0] e0, e1,
                      input logic [1:0] ev, ei,
                      input logic [38:0] pc0, pc1, npc0, npc1, va0, va1,
                      input logic [31:0] in0, in1);
    exp_t e;
    e.due = due; e.rv = rv; e.e0 = e0; e.e1 = e1; e.ev = ev; e.ei = ei;
    e.pc0 = pc0; e.pc1 = pc1; e.npc0 = npc0; e.npc1 = npc1;
    e.va0 = va0; e.va1 = va1; e.in0 = in0; e.in1 = in1;
    sb.push_back(e);
  endtask

  // One clock: drive issue/flush, drive retire from the scoreboard entry due
  // now, compare on the falling edge, then advance past the rising edge.
  task automatic step(input logic [1:0] iv, input logic [38:0] p0, p1,
                      input logic [31:0] i0, i1,
                      input logic [63:0] r0, m0, r1, m1, input logic fl);
    exp_t e;
    logic hit;
    bus.issue_v_i     = iv;
    bus.issue_pc_i    = {p1, p0};
    bus.issue_instr_i = {i1, i0};
    bus.issue_rs1_i   = {r1, r0};
    bus.issue_imm_i   = {m1, m0};
    bus.flush_i       = fl;
    hit = (sb.size() > 0) && (sb[0].due == cyc);
    if (hit) begin
      e = sb.pop_front();
      bus.retire_v_i         = e.rv;
      bus.retire_exception_i = {e.e1, e.e0};
    end else begin
      bus.retire_v_i         = '0;
      bus.retire_exception_i = '0;
    end
    @(negedge clk);
    if (hit) begin
      check_val($sformatf("c%0d_ret_v", cyc),     64'(bus.ret_v_o),          64'(e.ev));
      check_val($sformatf("c%0d_instret", cyc),   64'(bus.ret_instret_o),    64'(e.ei));
      check_val($sformatf("c%0d_pc0", cyc),       64'(bus.ret_pc_o[38:0]),   64'(e.pc0));
      check_val($sformatf("c%0d_pc1", cyc),       64'(bus.ret_pc_o[77:39]),  64'(e.pc1));
      check_val($sformatf("c%0d_npc0", cyc),      64'(bus.ret_npc_o[38:0]),  64'(e.npc0));
      check_val($sformatf("c%0d_npc1", cyc),      64'(bus.ret_npc_o[77:39]), 64'(e.npc1));
      check_val($sformatf("c%0d_vaddr", cyc),     64'(bus.ret_vaddr_o),      {e.va1[24:0], e.va0});
      check_val($sformatf("c%0d_instr", cyc),     64'(bus.ret_instr_o),      {e.in1, e.in0});
      check_val($sformatf("c%0d_exc", cyc),       64'(bus.ret_exception_o),
                64'({(e.ev[1] ? e.e1 : 16'h0), (e.ev[0] ? e.e0 : 16'h0)}));
    end else begin
      check_val($sformatf("c%0d_idle_v", cyc), 64'(bus.ret_v_o), 64'h0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Group whose effective address is pc + 0x10 on each lane
  task automatic grp(input logic [1:0] iv, input logic [38:0] p0, p1,
                     input logic [31:0] i0, i1, input logic fl);
    step(iv, p0, p1, i0, i1, 64'h10, 64'(p0), 64'h10, 64'(p1), fl);
  endtask

  task automatic idle(input logic fl);
    grp(2'b00, '0, '0, '0, '0, fl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.flush_i = 1'b0; bus.issue_v_i = '0; bus.issue_pc_i = '0; bus.issue_instr_i = '0;
    bus.issue_rs1_i = '0; bus.issue_imm_i = '0; bus.retire_v_i = '0; bus.retire_exception_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_ret_v", 64'(bus.ret_v_o), 64'h0);
    check_val("rst_cnt",   bus.instret_cnt_o, 64'h0);
    check_val("rst_err",   64'(bus.order_err_o), 64'h0);

    // c0: two-wide group; lane1 effective address overflows the vaddr width
    push(cyc + 2, 2'b11, 16'h0, 16'h0, 2'b11, 2'b11, 39'h100, 39'h104, 39'h104, 39'h108,
         39'h1010, 39'h0, c_nop, c_nop);
    step(2'b11, 39'h100, 39'h104, c_nop, c_nop, 64'h1000, 64'h10, 64'hFF_FFFF_FFFF, 64'h1, 1'b0);
    idle(1'b0); idle(1'b0);
    check_val("cnt_two", bus.instret_cnt_o, 64'd2);

    // c3: lane0 exception kills lane1, counter holds
    push(cyc + 2, 2'b11, 16'h0004, 16'h0, 2'b01, 2'b00, 39'h140, 39'h0, 39'h144, 39'h0,
         39'h150, 39'h0, c_nop, 32'h0);
    grp(2'b11, 39'h140, 39'h144, c_nop, c_nop, 1'b0);
    idle(1'b0); idle(1'b0);
    check_val("cnt_exc", bus.instret_cnt_o, 64'd2);

    // c6/c7: back-to-back groups, lane1 npc comes from stage 0
    push(cyc + 2, 2'b11, 16'h0, 16'h0, 2'b11, 2'b11, 39'h100, 39'h104, 39'h104, 39'h200,
         39'h110, 39'h114, c_nop, c_nop);
    grp(2'b11, 39'h100, 39'h104, c_nop, c_nop, 1'b0);
    push(cyc + 2, 2'b01, 16'h0, 16'h0, 2'b01, 2'b01, 39'h200, 39'h0, 39'h204, 39'h0,
         39'h210, 39'h0, c_nop, 32'h0);
    grp(2'b01, 39'h200, 39'h0, c_nop, c_nop, 1'b0);
    idle(1'b0); idle(1'b0);
    check_val("cnt_b2b", bus.instret_cnt_o, 64'd5);

    // c10..c13: flush of the stage-0 group while the prior group commits
    push(cyc + 2, 2'b11, 16'h0, 16'h0, 2'b11, 2'b11, 39'h500, 39'h504, 39'h504, 39'h508,
         39'h510, 39'h514, c_nop, c_nop);
    grp(2'b11, 39'h500, 39'h504, c_nop, c_nop, 1'b0);
    grp(2'b11, 39'h300, 39'h304, c_nop, c_nop, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check_val("cnt_flush", bus.instret_cnt_o, 64'd7);

    // c14: compressed instruction as a lone group
`ifdef BP_BE_RETIRE_RVC_EN
    push(cyc + 2, 2'b01, 16'h0, 16'h0, 2'b01, 2'b01, 39'h400, 39'h0, 39'h402, 39'h0,
         39'h410, 39'h0, 32'h4501, 32'h0);
`else
    push(cyc + 2, 2'b01, 16'h0, 16'h0, 2'b01, 2'b01, 39'h400, 39'h0, 39'h404, 39'h0,
         39'h410, 39'h0, 32'h4501, 32'h0);
`endif
    grp(2'b01, 39'h400, 39'h0, 32'h4501, 32'h0, 1'b0);
    idle(1'b0); idle(1'b0);
    check_val("cnt_rvc", bus.instret_cnt_o, 64'd8);

    // c17: lane1 retires while older lane0 holds back -> sticky error
    push(cyc + 2, 2'b10, 16'h0, 16'h0, 2'b10, 2'b10, 39'h0, 39'h604, 39'h0, 39'h608,
         39'h0, 39'h614, 32'h0, c_nop);
    grp(2'b11, 39'h600, 39'h604, c_nop, c_nop, 1'b0);
    check_val("err_before", 64'(bus.order_err_o), 64'h0);
    idle(1'b0); idle(1'b0);
    check_val("err_set",  64'(bus.order_err_o), 64'h1);
    check_val("cnt_err",  bus.instret_cnt_o, 64'd9);
    grp(2'b11, 39'h700, 39'h704, c_nop, c_nop, 1'b0);
    check_val("err_sticky", 64'(bus.order_err_o), 64'h1);

    // Reset mid-stream with a group in flight
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    check_val("mid_rst_v",   64'(bus.ret_v_o), 64'h0);
    check_val("mid_rst_cnt", bus.instret_cnt_o, 64'h0);
    check_val("mid_rst_err", 64'(bus.order_err_o), 64'h0);
    check_val("mid_rst_pc",  64'(bus.ret_pc_o), 64'h0);
    // The in-flight group must be gone: retiring now is an empty-lane retire
    push(cyc, 2'b11, 16'h0, 16'h0, 2'b00, 2'b00, 39'h0, 39'h0, 39'h0, 39'h0,
         39'h0, 39'h0, 32'h0, 32'h0);
    idle(1'b0);
    check_val("rst_drop_err", 64'(bus.order_err_o), 64'h1);
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    check_val("rst2_err", 64'(bus.order_err_o), 64'h0);
    check_val("rst2_cnt", bus.instret_cnt_o, 64'h0);

    // Flush again, then probe that the killed group left stage 1 empty
    push(cyc + 2, 2'b11, 16'h0, 16'h0, 2'b11, 2'b11, 39'h800, 39'h804, 39'h804, 39'h808,
         39'h810, 39'h814, c_nop, c_nop);
    grp(2'b11, 39'h800, 39'h804, c_nop, c_nop, 1'b0);
    grp(2'b11, 39'h900, 39'h904, c_nop, c_nop, 1'b0);
    idle(1'b1);
    push(cyc, 2'b01, 16'h0, 16'h0, 2'b00, 2'b00, 39'h0, 39'h0, 39'h0, 39'h0,
         39'h0, 39'h0, 32'h0, 32'h0);
    idle(1'b0);
    check_val("flush_kill_err", 64'(bus.order_err_o), 64'h1);
    check_val("cnt_final",      bus.instret_cnt_o, 64'd2);
    check_val("sb_drain",       64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_be_retire_collector.md
Name: bp_be_retire_collector

Overview:
- N-lane generalisation of the system-pipe retire-packet builder. Per-lane retire packet generation for an N-wide in-order backend.
- Captures each issued group (pc, instr, effective vaddr) and delays it two cycles to align with commit.
- Enforces in-order kill of younger lanes behind an older exception, and chains npc across lanes and into the next group.
- Keeps a running instret counter. Sits between dispatch and the CSR unit in the calculator.

Parameters:
lanes_p, 2, issue/retire width (1..4)
vaddr_width_p, 39, virtual address width
instr_width_p, 32, instruction width
dword_width_p, 64, rs1/imm/data width
exc_width_p, 16, per-lane exception vector width
cnt_width_p, 64, instret counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  kill all lanes of the stage-0 group
issue_v_i  in  lanes_p  per-lane issue valid
issue_pc_i  in  lanes_p*vaddr_width_p  per-lane pc, lane 0 oldest
issue_instr_i  in  lanes_p*instr_width_p  per-lane instruction
issue_rs1_i  in  lanes_p*dword_width_p  per-lane rs1
issue_imm_i  in  lanes_p*dword_width_p  per-lane immediate
retire_v_i  in  lanes_p  per-lane retire request, aligned to stage 1
retire_exception_i  in  lanes_p*exc_width_p  per-lane exception bits
ret_v_o  out  lanes_p  retire packet valid
ret_instret_o  out  lanes_p  retired without exception
ret_pc_o  out  lanes_p*vaddr_width_p  retiring pc
ret_npc_o  out  lanes_p*vaddr_width_p  next architectural pc
ret_vaddr_o  out  lanes_p*vaddr_width_p  rs1+imm, truncated to vaddr_width_p
ret_instr_o  out  lanes_p*instr_width_p  retiring instruction
ret_exception_o  out  lanes_p*exc_width_p  masked exception
instret_cnt_o  out  cnt_width_p  total retired instruction count
order_err_o  out  1  sticky protocol error flag

Behaviour:
Pipeline
- Stage 0 register: captures issue_v_i, pc, instr and vaddr every cycle. vaddr is computed before registering as lower vaddr_width_p bits of rs1+imm.
- Stage 1 register: copies stage 0 every cycle. When flush_i is high, stage 0 valids are written 0 instead.
- The issue-to-ret_* latency is exactly 2 cycles. Retire outputs are combinational from stage 1 and the retire_* inputs.

Lane qualification
- eff_v[k] = retire_v_i[k] & s1_v[k] & no_kill[k].
- no_kill[k] is low if any lane j<k has eff_v[j] and a nonzero exception.
- ret_v_o[k] = eff_v[k].
- ret_exception_o[k] = eff_v[k] ? exception : 0.
- ret_instret_o[k] = eff_v[k] & ~|exception.

npc
- For lane k: the pc of the lowest-index lane j>k with s1_v[j]. If none exists, the pc of the lowest valid stage-0 lane. If stage 0 is empty too, fallthrough = pc[k] + 4.

Counter
- instret_cnt_o increments by popcount(ret_instret_o) each cycle, using modulo 2^cnt_width_p wrap.

Protocol check
- order_err_o is set when retire_v_i[k] is high while s1_v[k] is low.
- It is also set when retire_v_i[k] is high while an older s1_v[j] lane has retire_v_i[j] low.
- Once set, it stays set until reset.

Reset
- Clears all stage valids, instret_cnt_o and order_err_o. All ret_* outputs are therefore 0.
- Reset has priority over flush_i and issue.

Simultaneous events
- flush_i does not affect the group in stage 1 (already committing).
- A stage-0 group killed by flush_i is invisible to npc selection the following cycle.

Optional Feature:
- BP_BE_RETIRE_RVC_EN defined: the fallthrough increment is +2 when instr[1:0] != 2'b11, and +4 otherwise.
- Undefined: the fallthrough increment is always +4. Instruction low bits are ignored.

Test Plan:
- Lanes_p=2, issue pc 0x100/0x104 both valid, retire both at +2 -> ret_v_o=11, ret_npc_o lane0=0x104, lane1=0x108 (fallthrough); instret_cnt_o 0->2.
- Lane0 exception=0x0004 with both retire_v -> ret_v_o=01, ret_exception_o lane0=0x0004, ret_instret_o=00, counter unchanged.
- Back-to-back groups {0x100,0x104} then {0x200,-}; retire first group -> lane1 npc=0x200 from stage 0.
- flush_i with group {0x300,0x304} in stage 0, retire_v_i=00 next cycle -> no outputs; prior group's npc falls through to pc+4.
- retire_v_i=10 with lane0 not retiring -> order_err_o=1, stays 1 until reset_i; reset mid-stream -> all outputs 0, counter 0 next cycle.
- With BP_BE_RETIRE_RVC_EN, compressed instr 0x4501 at 0x400, lone group -> ret_npc_o=0x402; without macro -> 0x404.
